// File: rtl/victim_cache.sv
// rtl/victim_cache.sv - fully-associative victim cache with LRU replacement and dirty drain (optional stats: VIC_CACHE_STATS_EN)

typedef logic [11:0] vic_tag_t;
typedef logic [5:0]  vic_idx_t;
typedef logic [31:0] vic_data_t;

typedef struct packed {
  logic      valid;
  logic      dirty;
  vic_tag_t  tag;
  vic_data_t data;
} vic_line_t;

typedef struct packed {
  vic_line_t line;
  vic_idx_t  idx;
} VIC_CACHE_T;

module victim_cache #(
  parameter int NUM_WAYS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  VIC_CACHE_T dc_evict,
  input  logic       dc_evict_valid,
  input  logic       lookup_valid,
  input  vic_tag_t   lookup_tag,
  input  vic_idx_t   lookup_idx,
  input  logic       rb_full,
  input  logic       flush,
  output logic       hit,
  output VIC_CACHE_T hit_line,
  output logic       stall,
  output VIC_CACHE_T evicted,
  output logic       evicted_valid,
  output logic       flush_done
`ifdef VIC_CACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_inserts,
  output logic [31:0] stat_writebacks
`endif
);

  localparam int AGE_W = $clog2(NUM_WAYS);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_WAYS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  VIC_CACHE_T       entries [NUM_WAYS];
  logic [AGE_W-1:0] ages    [NUM_WAYS];
  logic [1:0]       state;

  logic             hit_found;
  logic [AGE_W-1:0] hit_slot;
  logic             same_found;
  logic [AGE_W-1:0] same_slot;
  logic             inv_found;
  logic [AGE_W-1:0] inv_slot;
  logic [AGE_W-1:0] lru_slot;
  logic [AGE_W-1:0] lru_age;
  logic             drain_found;
  logic [AGE_W-1:0] drain_slot;
  logic             drain_fire;
  logic             dirty_left;

  logic             insert_req;
  logic             write_en;
  logic [AGE_W-1:0] write_slot;
  logic [AGE_W-1:0] prev_age;

  // Slot searches: lookup match, same-address match, first free, LRU victim, next dirty to drain
  always_comb begin
    hit_found   = 1'b0;
    hit_slot    = '0;
    same_found  = 1'b0;
    same_slot   = '0;
    inv_found   = 1'b0;
    inv_slot    = '0;
    lru_slot    = '0;
    lru_age     = ages[0];
    drain_found = 1'b0;
    drain_slot  = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!hit_found && lookup_valid && entries[i].line.valid &&
          entries[i].line.tag == lookup_tag && entries[i].idx == lookup_idx) begin
        hit_found = 1'b1;
        hit_slot  = AGE_W'(i);
      end
      if (!same_found && entries[i].line.valid &&
          entries[i].line.tag == dc_evict.line.tag && entries[i].idx == dc_evict.idx) begin
        same_found = 1'b1;
        same_slot  = AGE_W'(i);
      end
      if (!inv_found && !entries[i].line.valid) begin
        inv_found = 1'b1;
        inv_slot  = AGE_W'(i);
      end
      if (ages[i] > lru_age) begin
        lru_age  = ages[i];
        lru_slot = AGE_W'(i);
      end
      if (!drain_found && entries[i].line.valid && entries[i].line.dirty) begin
        drain_found = 1'b1;
        drain_slot  = AGE_W'(i);
      end
    end
    drain_fire = !reset && state == ST_FLUSH && drain_found && !rb_full;
    dirty_left = 1'b0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (entries[i].line.valid && entries[i].line.dirty &&
          !(drain_fire && AGE_W'(i) == drain_slot)) begin
        dirty_left = 1'b1;
      end
    end
  end

  // Outputs and the insertion decision, all combinational from state and inputs
  always_comb begin
    insert_req    = !reset && state == ST_IDLE && dc_evict_valid && dc_evict.line.valid;
    hit           = !reset && state == ST_IDLE && hit_found;
    hit_line      = hit ? entries[hit_slot] : '0;
    write_en      = 1'b0;
    write_slot    = hit_slot;
    stall         = 1'b0;
    evicted       = '0;
    evicted_valid = 1'b0;
    flush_done    = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          if (insert_req) begin
            if (hit_found) begin
              write_en   = 1'b1;
              write_slot = hit_slot;
            end else if (same_found) begin
              write_en   = 1'b1;
              write_slot = same_slot;
            end else if (inv_found) begin
              write_en   = 1'b1;
              write_slot = inv_slot;
            end else if (entries[lru_slot].line.dirty) begin
              if (rb_full) begin
                stall = 1'b1;
              end else begin
                write_en      = 1'b1;
                write_slot    = lru_slot;
                evicted       = entries[lru_slot];
                evicted_valid = 1'b1;
              end
            end else begin
              write_en   = 1'b1;
              write_slot = lru_slot;
            end
          end
        end
        ST_FLUSH: begin
          stall = 1'b1;
          if (drain_fire) begin
            evicted       = entries[drain_slot];
            evicted_valid = 1'b1;
          end
        end
        ST_DONE: begin
          stall      = 1'b1;
          flush_done = 1'b1;
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
    prev_age = entries[write_slot].line.valid ? ages[write_slot] : AGE_MAX;
  end

  // Entry, age and FSM update
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        entries[i] <= '0;
        ages[i]    <= '0;
      end
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (write_en) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
              if (AGE_W'(i) != write_slot && entries[i].line.valid && ages[i] < prev_age) begin
                ages[i] <= ages[i] + 1'b1;
              end
            end
            entries[write_slot] <= dc_evict;
            ages[write_slot]    <= '0;
          end else if (hit) begin
            entries[hit_slot].line.valid <= 1'b0;
          end
          if (flush) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          for (int i = 0; i < NUM_WAYS; i++) begin
            if (!entries[i].line.dirty || (drain_fire && AGE_W'(i) == drain_slot)) begin
              entries[i].line.valid <= 1'b0;
            end
          end
          if (!dirty_left) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef VIC_CACHE_STATS_EN
  // Event counters, wrapping modulo 2^32
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_hits       <= '0;
      stat_inserts    <= '0;
      stat_writebacks <= '0;
    end else begin
      if (hit) stat_hits <= stat_hits + 32'd1;
      if (write_en) stat_inserts <= stat_inserts + 32'd1;
      if (evicted_valid) stat_writebacks <= stat_writebacks + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_victim_cache.sv
// tb/tb_victim_cache.sv - directed bench for victim_cache with a reference model

module tb_victim_cache;

  logic       clock = 1'b0;
  logic       reset;
  VIC_CACHE_T dc_evict;
  logic       dc_evict_valid;
  logic       lookup_valid;
  vic_tag_t   lookup_tag;
  vic_idx_t   lookup_idx;
  logic       rb_full;
  logic       flush;
  logic       hit;
  VIC_CACHE_T hit_line;
  logic       stall;
  VIC_CACHE_T evicted;
  logic       evicted_valid;
  logic       flush_done;
`ifdef VIC_CACHE_STATS_EN
  logic [31:0] stat_hits, stat_inserts, stat_writebacks;
`endif

  victim_cache #(.NUM_WAYS(4)) dut (
    .clock(clock), .reset(reset), .dc_evict(dc_evict), .dc_evict_valid(dc_evict_valid),
    .lookup_valid(lookup_valid), .lookup_tag(lookup_tag), .lookup_idx(lookup_idx),
    .rb_full(rb_full), .flush(flush), .hit(hit), .hit_line(hit_line), .stall(stall),
    .evicted(evicted), .evicted_valid(evicted_valid), .flush_done(flush_done)
`ifdef VIC_CACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_inserts(stat_inserts), .stat_writebacks(stat_writebacks)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: four slots with spec-defined ages, mode 0=idle 1=flush 2=done
  VIC_CACHE_T m_ent [4];
  int         m_age [4];
  int         m_mode = 0;

  logic       e_hit, e_stall, e_evv, e_done;
  VIC_CACHE_T e_hline, e_ev;
  int         e_tgt, e_hslot, e_emit;

  function automatic bit same_addr(input VIC_CACHE_T a, input vic_tag_t t, input vic_idx_t x);
    return a.line.valid && a.line.tag == t && a.idx == x;
  endfunction

  function automatic void model_eval();
    int best;
    e_hit = 0; e_stall = 0; e_evv = 0; e_done = 0;
    e_hline = '0; e_ev = '0; e_tgt = -1; e_hslot = -1; e_emit = -1;
    if (reset) return;
    if (m_mode == 0) begin
      if (lookup_valid)
        for (int i = 0; i < 4; i++)
          if (e_hslot < 0 && same_addr(m_ent[i], lookup_tag, lookup_idx)) e_hslot = i;
      if (e_hslot >= 0) begin
        e_hit = 1;
        e_hline = m_ent[e_hslot];
      end
      if (dc_evict_valid && dc_evict.line.valid) begin
        if (e_hslot >= 0) e_tgt = e_hslot;
        if (e_tgt < 0)
          for (int i = 0; i < 4; i++)
            if (e_tgt < 0 && same_addr(m_ent[i], dc_evict.line.tag, dc_evict.idx)) e_tgt = i;
        if (e_tgt < 0)
          for (int i = 0; i < 4; i++)
            if (e_tgt < 0 && !m_ent[i].line.valid) e_tgt = i;
        if (e_tgt < 0) begin
          best = 0;
          for (int i = 1; i < 4; i++) if (m_age[i] > m_age[best]) best = i;
          if (!m_ent[best].line.dirty) e_tgt = best;
          else if (rb_full) e_stall = 1;
          else begin
            e_tgt = best;
            e_evv = 1;
            e_ev = m_ent[best];
          end
        end
      end
    end else begin
      e_stall = 1;
      e_done = (m_mode == 2);
      if (m_mode == 1 && !rb_full)
        for (int i = 0; i < 4; i++)
          if (e_emit < 0 && m_ent[i].line.valid && m_ent[i].line.dirty) e_emit = i;
      if (e_emit >= 0) begin
        e_evv = 1;
        e_ev = m_ent[e_emit];
      end
    end
  endfunction

  function automatic void model_commit();
    int prev;
    bit left;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_ent[i] = '0;
        m_age[i] = 0;
      end
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (e_tgt >= 0) begin
        prev = m_ent[e_tgt].line.valid ? m_age[e_tgt] : 3;
        for (int i = 0; i < 4; i++)
          if (i != e_tgt && m_ent[i].line.valid && m_age[i] < prev) m_age[i]++;
        m_ent[e_tgt] = dc_evict;
        m_age[e_tgt] = 0;
      end else if (e_hslot >= 0) begin
        m_ent[e_hslot].line.valid = 1'b0;
      end
      if (flush) m_mode = 1;
    end else if (m_mode == 1) begin
      for (int i = 0; i < 4; i++)
        if (!m_ent[i].line.dirty || i == e_emit) m_ent[i].line.valid = 1'b0;
      left = 0;
      for (int i = 0; i < 4; i++)
        if (m_ent[i].line.valid && m_ent[i].line.dirty) left = 1;
      if (!left) m_mode = 2;
    end
  endfunction

  // Model advances on the same edge as the DUT, using the inputs held across it
  always @(posedge clock) begin
    model_eval();
    model_commit();
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clock) begin
    model_eval();
    check("hit", hit, e_hit);
    check("hit_line", hit_line, e_hline);
    check("stall", stall, e_stall);
    check("evicted_valid", evicted_valid, e_evv);
    check("flush_done", flush_done, e_done);
    if (e_evv || reset) check("evicted", evicted, e_ev);
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    dc_evict_valid = 0;
    dc_evict = '0;
    lookup_valid = 0;
    lookup_tag = '0;
    lookup_idx = '0;
    flush = 0;
  endtask

  task automatic put(input int tag, input int idx, input bit dirty, input int data);
    dc_evict.line.valid = 1'b1;
    dc_evict.line.dirty = dirty;
    dc_evict.line.tag = vic_tag_t'(tag);
    dc_evict.line.data = vic_data_t'(data);
    dc_evict.idx = vic_idx_t'(idx);
    dc_evict_valid = 1'b1;
  endtask

  task automatic look(input int tag, input int idx);
    lookup_valid = 1'b1;
    lookup_tag = vic_tag_t'(tag);
    lookup_idx = vic_idx_t'(idx);
  endtask

  int rb_seq [5] = '{1, 0, 1, 0, 0};
  int ev_idx [5] = '{-1, 1, -1, 9, 3};
  int n_flush_ev;

  initial begin
    reset = 1;
    rb_full = 0;
    clr();
    put(1, 1, 1, 1);
    look(1, 1);
    #2;
    check("reset_hit", hit, 0);
    check("reset_stall", stall, 0);
    check("reset_evv", evicted_valid, 0);
    cyc();
    cyc();
    reset = 0;
    clr();
    look(5, 2);
    #2;
    check("post_reset_hit_line", hit_line, 0);
    cyc();
    clr();

    for (int i = 0; i < 4; i++) begin
      put(5, i, 0, 100 + i);
      #2;
      check("fill_stall", stall, 0);
      check("fill_evv", evicted_valid, 0);
      cyc();
      clr();
    end

    look(5, 2);
    #2;
    check("lookup_hit", hit, 1);
    check("lookup_data", hit_line.line.data, 102);
    cyc();
    clr();
    look(5, 2);
    #2;
    check("lookup_again_miss", hit, 0);
    cyc();
    clr();

    put(5, 9, 1, 'h900); cyc(); clr();
    put(5, 0, 1, 'hD00); cyc(); clr();
    put(5, 1, 1, 'hD01); cyc(); clr();
    put(5, 3, 1, 'hD03); cyc(); clr();
    put(5, 9, 1, 'h901); cyc(); clr();

    rb_full = 1;
    put(7, 4, 1, 'h744);
    #2;
    check("bp_stall", stall, 1);
    check("bp_evv", evicted_valid, 0);
    cyc();
    rb_full = 0;
    #2;
    check("bp_release_stall", stall, 0);
    check("bp_release_evv", evicted_valid, 1);
    check("bp_evicted_idx", evicted.idx, 0);
    check("bp_evicted_data", evicted.line.data, 'hD00);
    cyc();
    clr();

    rb_full = 1;
    look(5, 1);
    put(8, 10, 1, 'h8AA);
    #2;
    check("swap_hit", hit, 1);
    check("swap_hit_data", hit_line.line.data, 'hD01);
    check("swap_evv", evicted_valid, 0);
    check("swap_stall", stall, 0);
    cyc();
    clr();
    rb_full = 0;

    look(8, 10);
    #2;
    check("swap_resident", hit_line.line.data, 'h8AA);
    cyc();
    clr();
    look(7, 4);
    #2;
    check("bp_line_resident", hit_line.line.data, 'h744);
    cyc();
    clr();

    put(5, 0, 0, 'hC00); cyc(); clr();
    put(6, 1, 1, 'h611); cyc(); clr();
    flush = 1;
    cyc();
    clr();
    n_flush_ev = 0;
    for (int k = 0; k < 5; k++) begin
      rb_full = rb_seq[k][0];
      #2;
      check("drain_stall", stall, 1);
      check("drain_evv", evicted_valid, ev_idx[k] >= 0);
      if (ev_idx[k] >= 0) check("drain_idx", evicted.idx, ev_idx[k]);
      if (evicted_valid) n_flush_ev++;
      cyc();
    end
    rb_full = 0;
    #2;
    check("flush_done", flush_done, 1);
    check("flush_ev_count", n_flush_ev, 3);
    flush = 1;
    cyc();
    clr();
    #2;
    check("flush_in_done_ignored", flush_done, 1);

    reset = 1;
    cyc();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      put(3, i, 0, 'h300 + i);
      cyc();
      clr();
    end
    rb_full = 1;
    put(3, 4, 0, 'h304);
    #2;
    check("clean_drop_stall", stall, 0);
    check("clean_drop_evv", evicted_valid, 0);
    cyc();
    clr();
    rb_full = 0;
    put(3, 1, 1, 'h311); cyc(); clr();
    put(3, 2, 1, 'h322); cyc(); clr();
    flush = 1;
    cyc();
    clr();
    #2;
    check("drain2_idx", evicted.idx, 1);
    cyc();
    reset = 1;
    #2;
    check("mid_reset_evv", evicted_valid, 0);
    check("mid_reset_stall", stall, 0);
    cyc();
    reset = 0;
    #2;
    check("after_reset_stall", stall, 0);
    check("after_reset_done", flush_done, 0);
    check("after_reset_evv", evicted_valid, 0);
    look(3, 2);
    #2;
    check("after_reset_dropped", hit, 0);
    cyc();
    clr();
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
